// File: rtl/single_to_unsigned_int.sv
// IEEE-754 single-precision to 32-bit unsigned integer converter. It uses a strobe/ack
// stream interface, truncates toward zero, saturates out-of-range values and aligns with a serial shifter.
module single_to_unsigned_int #(
  parameter logic [31:0] NAN_RESULT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    CONVERT = 3'd3,
    PUT_Z   = 3'd4
  } state_t;

  state_t                     state, state_nxt;
  logic        [DATA_W-1:0]   a_reg, a_nxt;
  logic                       s_reg, s_nxt;
  logic signed [EXP_W-1:0]    e_reg, e_nxt;
  logic        [DATA_W-1:0]   m_reg, m_nxt;
  logic        [DATA_W-1:0]   z_reg, z_nxt;
  logic        [CNT_W-1:0]    cnt, cnt_nxt;
  logic                       ack_q, ack_nxt;
  logic                       stb_q, stb_nxt;
  logic        [DATA_W-1:0]   out_q, out_nxt;

  logic                       accept_c;
  logic                       release_c;
  logic                       exp_max_c;
  logic                       frac_nz_c;

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_q;

  assign accept_c  = input_a_stb && ack_q;
  assign release_c = stb_q && output_z_ack;
  assign exp_max_c = (a_reg[30:23] == 8'hFF);
  assign frac_nz_c = (a_reg[22:0] != 23'd0);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GET_A;
      a_reg <= '0;
      s_reg <= 1'b0;
      e_reg <= '0;
      m_reg <= '0;
      z_reg <= '0;
      cnt   <= '0;
      ack_q <= 1'b0;
      stb_q <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      a_reg <= a_nxt;
      s_reg <= s_nxt;
      e_reg <= e_nxt;
      m_reg <= m_nxt;
      z_reg <= z_nxt;
      cnt   <= cnt_nxt;
      ack_q <= ack_nxt;
      stb_q <= stb_nxt;
      out_q <= out_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    s_nxt     = s_reg;
    e_nxt     = e_reg;
    m_nxt     = m_reg;
    z_nxt     = z_reg;
    cnt_nxt   = cnt;
    out_nxt   = out_q;

    case (state)
      GET_A: begin
        if (accept_c) begin
          a_nxt     = input_a;
          state_nxt = UNPACK;
        end
      end

      UNPACK: begin
        s_nxt     = a_reg[31];
        e_nxt     = $signed(EXP_W'({2'b00, a_reg[30:23]}) - EXP_W'(127));
        m_nxt     = {1'b1, a_reg[22:0], 8'h00};
        state_nxt = SPECIAL;
      end

      SPECIAL: begin
        state_nxt = PUT_Z;
        if (exp_max_c && frac_nz_c) begin
          out_nxt = NAN_RESULT;
        end else if (s_reg) begin
          out_nxt = '0;
        end else if (exp_max_c || (e_reg >= 10'sd32)) begin
          out_nxt = '1;
        end else if (e_reg < 10'sd0) begin
          out_nxt = '0;
        end else begin
          z_nxt     = m_reg;
          cnt_nxt   = CNT_W'(31) - e_reg[CNT_W-1:0];
          state_nxt = CONVERT;
        end
      end

      // One bit per cycle; bits shifted out are dropped (truncation)
      CONVERT: begin
        if (cnt == '0) begin
          out_nxt   = z_reg;
          state_nxt = PUT_Z;
        end else begin
          z_nxt   = z_reg >> 1;
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      PUT_Z: begin
        if (release_c) begin
          state_nxt = GET_A;
        end
      end

      default: state_nxt = GET_A;
    endcase

    // Handshake flags lag their state by a cycle, so ack and stb never overlap
    ack_nxt = (state == GET_A) && (state_nxt == GET_A);
    stb_nxt = (state == PUT_Z) && (state_nxt == PUT_Z);
  end

endmodule

// File: tb/tb_single_to_unsigned_int.sv
// Directed and reference-model checks for single_to_unsigned_int: results,
// latency, handshake stalls and mid-conversion reset.
module tb_single_to_unsigned_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int errors = 0;

  single_to_unsigned_int dut (
    .clk         (clk),
    .rst         (rst),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Independent reference: integer scaling of the 24-bit significand
  function automatic logic [31:0] ref_z(input logic [31:0] a);
    logic [7:0]  ex;
    logic [31:0] mant;
    ex   = a[30:23];
    mant = {8'h00, 1'b1, a[22:0]};
    if (ex == 8'hFF && a[22:0] != 0) return 32'h0;
    if (a[31]) return 32'h0;
    if (ex == 8'hFF || ex >= 8'd159) return 32'hFFFF_FFFF;
    if (ex < 8'd127) return 32'h0;
    if (ex >= 8'd150) return mant << (ex - 8'd150);
    return mant >> (8'd150 - ex);
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    logic [7:0] ex;
    ex = a[30:23];
    if (ex == 8'hFF || a[31] || ex >= 8'd159 || ex < 8'd127) return 3;
    return 4 + (158 - int'(ex));
  endfunction

  // Offer one operand, wait for the result and compare value and latency
  task automatic run_op(input logic [31:0] a, input logic [31:0] z_exp, input int lat_exp,
                        input string tag);
    bit got;
    int lat;
    input_a     = a;
    input_a_stb = 1'b1;
    got         = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      got = input_a_ack;
      @(posedge clk); #1;
    end
    input_a_stb = 1'b0;
    input_a     = $urandom;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout actual=0 expected=1", tag);
      return;
    end
    lat = 0;
    while (!output_z_stb && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_z"}, output_z, z_exp);
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_ack_busy"}, {31'd0, input_a_ack}, 32'd0);
    if (output_z_ack) begin
      @(posedge clk); #1;
      check({tag, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 35};
    vecs[1]  = '{32'h42F7_8000, 32'h0000_007B, 29};
    vecs[2]  = '{32'h4F7F_FFFF, 32'hFFFF_FF00, 4};
    vecs[3]  = '{32'h3F7F_FFFF, 32'h0000_0000, 3};
    vecs[4]  = '{32'h4F80_0000, 32'hFFFF_FFFF, 3};
    vecs[5]  = '{32'h7F80_0000, 32'hFFFF_FFFF, 3};
    vecs[6]  = '{32'hBF80_0000, 32'h0000_0000, 3};
    vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 3};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0000, 3};
    vecs[9]  = '{32'h7FC0_0000, 32'h0000_0000, 3};
    vecs[10] = '{32'hFF80_0000, 32'h0000_0000, 3};
    vecs[11] = '{32'h7F80_0001, 32'h0000_0000, 3};
    vecs[12] = '{32'h4000_0000, 32'h0000_0002, 34};
    vecs[13] = '{32'h4B00_0000, 32'h0080_0000, 12};

    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, input_a_ack}, 32'd0);
    check("rst_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack", {31'd0, input_a_ack}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].z, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Consumer stalls for 10 cycles in PUT_Z
    output_z_ack = 1'b0;
    run_op(32'h42F7_8000, 32'h0000_007B, 29, "stall");
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_stb", {31'd0, output_z_stb}, 32'd1);
      check("stall_z", output_z, 32'h0000_007B);
      check("stall_ack", {31'd0, input_a_ack}, 32'd0);
    end
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    check("stall_release_stb", {31'd0, output_z_stb}, 32'd0);
    check("stall_release_ack", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk); #1;
    check("stall_ack_back", {31'd0, input_a_ack}, 32'd1);

    // Reset in the middle of a long conversion
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_stb", {31'd0, output_z_stb}, 32'd0);
    check("midrst_ack", {31'd0, input_a_ack}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack_back", {31'd0, input_a_ack}, 32'd1);
    check("midrst_stb_idle", {31'd0, output_z_stb}, 32'd0);
    run_op(32'h42F7_8000, 32'h0000_007B, 29, "after_rst");

    // Random operands biased toward the interesting exponent range
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      if (i % 4 != 0) ra[30:23] = 8'($urandom_range(120, 165));
      if (i % 4 != 0) ra[31] = (i % 7 == 0);
      run_op(ra, ref_z(ra), ref_lat(ra), $sformatf("rnd%0d_%h", i, ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
